// File: rtl/ball_collision_writer_pkg.sv
// Shared types and widths for the billiard ball collision logic.
package billiard_pkg;

    localparam int VEL_W   = 11;
    localparam int POS_W   = 11;
    localparam int DIFF_W  = 12;
    localparam int DIST2_W = 25;

    typedef struct packed {
        logic        [POS_W-1:0] posX;
        logic        [POS_W-1:0] posY;
        logic signed [VEL_W-1:0] velX;
        logic signed [VEL_W-1:0] velY;
    } ball_state_t;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DETECT,
        RESOLVE,
        WRITE
    } collision_state_t;

    // Magnitude of a 12-bit signed difference; -2048 maps to 2048 as unsigned.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] value);
        return value[DIFF_W-1] ? DIFF_W'(-value) : DIFF_W'(value);
    endfunction

endpackage

// File: rtl/ball_collision_writer_if.sv
// Frame tick, ball pair state and velocity write-back bundle.
interface ball_collision_if;
    import billiard_pkg::*;

    logic                    startOfFrame;
    logic                    enable;
    logic        [POS_W-1:0] posAX;
    logic        [POS_W-1:0] posAY;
    logic signed [VEL_W-1:0] velAX;
    logic signed [VEL_W-1:0] velAY;
    logic        [POS_W-1:0] posBX;
    logic        [POS_W-1:0] posBY;
    logic signed [VEL_W-1:0] velBX;
    logic signed [VEL_W-1:0] velBY;

    logic                    velocityWriteEnableA;
    logic signed [VEL_W-1:0] outVelocityAX;
    logic signed [VEL_W-1:0] outVelocityAY;
    logic                    velocityWriteEnableB;
    logic signed [VEL_W-1:0] outVelocityBX;
    logic signed [VEL_W-1:0] outVelocityBY;
    logic                    collisionPulse;
    logic                    busy;
    logic             [15:0] collisionCount;

    // Controller / ball side: drives frame tick and ball state, observes writes.
    modport master (
        output startOfFrame, enable,
        output posAX, posAY, velAX, velAY,
        output posBX, posBY, velBX, velBY,
        input  velocityWriteEnableA, outVelocityAX, outVelocityAY,
        input  velocityWriteEnableB, outVelocityBX, outVelocityBY,
        input  collisionPulse, busy, collisionCount
    );

    // Collision writer side.
    modport slave (
        input  startOfFrame, enable,
        input  posAX, posAY, velAX, velAY,
        input  posBX, posBY, velBX, velBY,
        output velocityWriteEnableA, outVelocityAX, outVelocityAY,
        output velocityWriteEnableB, outVelocityBX, outVelocityBY,
        output collisionPulse, busy, collisionCount
    );

endinterface

// File: rtl/ball_collision_writer_collision_detect.sv
// Combinational overlap test, dominant-axis choice and closing test for a ball pair.
module collision_detect
    import billiard_pkg::*;
#(
    parameter int BALL_DIAMETER = 32
) (
    input  ball_state_t ball_a,
    input  ball_state_t ball_b,
    output logic        hit,
    output logic        axisIsX,
    output logic        closing
);

    logic signed [DIFF_W-1:0]  dx;
    logic signed [DIFF_W-1:0]  dy;
    logic signed [DIST2_W-1:0] dx_ext;
    logic signed [DIST2_W-1:0] dy_ext;
    logic        [DIST2_W-1:0] d2;
    logic        [DIFF_W-1:0]  abs_dx;
    logic        [DIFF_W-1:0]  abs_dy;
    logic signed [DIFF_W-1:0]  d_dom;
    logic signed [DIFF_W-1:0]  vel_a_dom;
    logic signed [DIFF_W-1:0]  vel_b_dom;
    logic signed [DIFF_W-1:0]  rel;

    // Squared centre distance against diameter squared, then approach direction on the larger axis.
    always_comb begin
        dx     = $signed({1'b0, ball_a.posX}) - $signed({1'b0, ball_b.posX});
        dy     = $signed({1'b0, ball_a.posY}) - $signed({1'b0, ball_b.posY});
        dx_ext = DIST2_W'(dx);
        dy_ext = DIST2_W'(dy);
        d2     = DIST2_W'(dx_ext * dx_ext + dy_ext * dy_ext);
        hit    = d2 < DIST2_W'(BALL_DIAMETER * BALL_DIAMETER);

        abs_dx  = abs_diff(dx);
        abs_dy  = abs_diff(dy);
        axisIsX = abs_dx >= abs_dy;

        if (axisIsX) begin
            d_dom     = dx;
            vel_a_dom = DIFF_W'($signed(ball_a.velX));
            vel_b_dom = DIFF_W'($signed(ball_b.velX));
        end else begin
            d_dom     = dy;
            vel_a_dom = DIFF_W'($signed(ball_a.velY));
            vel_b_dom = DIFF_W'($signed(ball_b.velY));
        end

        rel     = vel_a_dom - vel_b_dom;
        closing = (!d_dom[DIFF_W-1] && (d_dom != '0) && rel[DIFF_W-1]) ||
                  (d_dom[DIFF_W-1] && !rel[DIFF_W-1] && (rel != '0));
    end

endmodule

// File: rtl/ball_collision_writer.sv
// Per-frame collision check for one ball pair with elastic velocity swap write-back.
module ball_collision_writer
    import billiard_pkg::*;
#(
    parameter int BALL_DIAMETER   = 32,
    parameter int COOLDOWN_FRAMES = 4
) (
    input logic              clk,
    input logic              reset,
    ball_collision_if.slave  bus
);

    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    collision_state_t state;
    collision_state_t next_state;

    ball_state_t ball_a_q;
    ball_state_t ball_b_q;

    logic hit;
    logic axis_x;
    logic closing;
    logic hit_q;
    logic axis_x_q;
    logic closing_q;
    logic suppressed_q;
    logic do_write;

    logic [CD_W-1:0] cooldown_q;

    logic frame_start;
    logic capture_en;
    logic detect_en;
    logic resolve_en;
    logic busy;

    logic                    write_a_q;
    logic                    write_b_q;
    logic                    pulse_q;
    logic signed [VEL_W-1:0] out_ax_q;
    logic signed [VEL_W-1:0] out_ay_q;
    logic signed [VEL_W-1:0] out_bx_q;
    logic signed [VEL_W-1:0] out_by_q;
    logic             [15:0] count_q;

    collision_detect #(
        .BALL_DIAMETER(BALL_DIAMETER)
    ) u_detect (
        .ball_a (ball_a_q),
        .ball_b (ball_b_q),
        .hit    (hit),
        .axisIsX(axis_x),
        .closing(closing)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: only IDLE waits; every other state advances after one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.startOfFrame && bus.enable) next_state = CAPTURE;
            CAPTURE: next_state = DETECT;
            DETECT:  next_state = RESOLVE;
            RESOLVE: next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state datapath enables and the busy flag.
    always_comb begin
        busy        = 1'b0;
        frame_start = 1'b0;
        capture_en  = 1'b0;
        detect_en   = 1'b0;
        resolve_en  = 1'b0;
        case (state)
            IDLE:    frame_start = bus.startOfFrame && bus.enable;
            CAPTURE: begin busy = 1'b1; capture_en = 1'b1; end
            DETECT:  begin busy = 1'b1; detect_en  = 1'b1; end
            RESOLVE: begin busy = 1'b1; resolve_en = 1'b1; end
            WRITE:   busy = 1'b1;
            default: ;
        endcase
    end

    assign do_write = hit_q && closing_q && !suppressed_q;

    // Frame datapath: cooldown, capture, detect results and the registered write-back loaded into WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ball_a_q     <= '0;
            ball_b_q     <= '0;
            hit_q        <= 1'b0;
            axis_x_q     <= 1'b0;
            closing_q    <= 1'b0;
            suppressed_q <= 1'b0;
            cooldown_q   <= '0;
            write_a_q    <= 1'b0;
            write_b_q    <= 1'b0;
            pulse_q      <= 1'b0;
            out_ax_q     <= '0;
            out_ay_q     <= '0;
            out_bx_q     <= '0;
            out_by_q     <= '0;
            count_q      <= '0;
        end else begin
            write_a_q <= 1'b0;
            write_b_q <= 1'b0;
            pulse_q   <= 1'b0;

            if (frame_start) begin
                suppressed_q <= (cooldown_q != '0);
                if (cooldown_q != '0) begin
                    cooldown_q <= cooldown_q - CD_W'(1);
                end
            end

            if (capture_en) begin
                ball_a_q <= '{posX: bus.posAX, posY: bus.posAY, velX: bus.velAX, velY: bus.velAY};
                ball_b_q <= '{posX: bus.posBX, posY: bus.posBY, velX: bus.velBX, velY: bus.velBY};
            end

            if (detect_en) begin
                hit_q     <= hit;
                axis_x_q  <= axis_x;
                closing_q <= closing;
            end

            if (resolve_en && do_write) begin
                write_a_q  <= 1'b1;
                write_b_q  <= 1'b1;
                pulse_q    <= 1'b1;
                out_ax_q   <= axis_x_q ? ball_b_q.velX : ball_a_q.velX;
                out_ay_q   <= axis_x_q ? ball_a_q.velY : ball_b_q.velY;
                out_bx_q   <= axis_x_q ? ball_a_q.velX : ball_b_q.velX;
                out_by_q   <= axis_x_q ? ball_b_q.velY : ball_a_q.velY;
                count_q    <= count_q + 16'd1;
                cooldown_q <= CD_W'(COOLDOWN_FRAMES);
            end
        end
    end

    assign bus.velocityWriteEnableA = write_a_q;
    assign bus.velocityWriteEnableB = write_b_q;
    assign bus.collisionPulse       = pulse_q;
    assign bus.outVelocityAX        = out_ax_q;
    assign bus.outVelocityAY        = out_ay_q;
    assign bus.outVelocityBX        = out_bx_q;
    assign bus.outVelocityBY        = out_by_q;
    assign bus.busy                 = busy;
    assign bus.collisionCount       = count_q;

endmodule

// File: tb/tb_ball_collision_writer.sv
// Directed bench for ball_collision_writer: hits, misses, boundaries, cooldown, reset and enable.
module tb_ball_collision_writer;
    import billiard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ball_collision_if bus();

    ball_collision_writer #(
        .BALL_DIAMETER  (32),
        .COOLDOWN_FRAMES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    task automatic applyStimulus(input int ax, input int ay, input int avx, input int avy,
                                 input int bx, input int by, input int bvx, input int bvy);
        bus.posAX = 11'(ax);
        bus.posAY = 11'(ay);
        bus.velAX = 11'(avx);
        bus.velAY = 11'(avy);
        bus.posBX = 11'(bx);
        bus.posBY = 11'(by);
        bus.velBX = 11'(bvx);
        bus.velBY = 11'(bvy);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic checkVelocities(input string tag, input int ax, input int ay, input int bx, input int by);
        checkOutput({tag, " outAX"}, 32'($signed(bus.outVelocityAX)), 32'(ax));
        checkOutput({tag, " outAY"}, 32'($signed(bus.outVelocityAY)), 32'(ay));
        checkOutput({tag, " outBX"}, 32'($signed(bus.outVelocityBX)), 32'(bx));
        checkOutput({tag, " outBY"}, 32'($signed(bus.outVelocityBY)), 32'(by));
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " busy"},    32'(bus.busy), 32'd0);
        checkOutput({tag, " strobeA"}, 32'(bus.velocityWriteEnableA), 32'd0);
        checkOutput({tag, " strobeB"}, 32'(bus.velocityWriteEnableB), 32'd0);
        checkOutput({tag, " pulse"},   32'(bus.collisionPulse), 32'd0);
        checkOutput({tag, " count"},   32'(bus.collisionCount), 32'd0);
        checkVelocities(tag, 0, 0, 0, 0);
    endtask

    // One frame: tick in cycle N, then check busy and strobes in N+1..N+5.
    task automatic runFrame(input string tag, input bit expWrite, input bit midSof);
        bus.startOfFrame = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            nextCycle();
            bus.startOfFrame = midSof && (c == 2);
            checkOutput($sformatf("%s busy@N+%0d", tag, c),    32'(bus.busy), 32'(c <= 4));
            checkOutput($sformatf("%s strobeA@N+%0d", tag, c), 32'(bus.velocityWriteEnableA), 32'(expWrite && (c == 4)));
            checkOutput($sformatf("%s strobeB@N+%0d", tag, c), 32'(bus.velocityWriteEnableB), 32'(expWrite && (c == 4)));
            checkOutput($sformatf("%s pulse@N+%0d", tag, c),   32'(bus.collisionPulse), 32'(expWrite && (c == 4)));
        end
    endtask

    initial begin
        int seen;

        reset            = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.enable       = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        reset = 1'b0;

        $display("[TB] reset state");
        checkIdleZero("reset");

        $display("[TB] head-on X hit");
        applyStimulus(100, 100, 5, 0, 120, 100, -3, 0);
        runFrame("headon", 1'b1, 1'b0);
        checkVelocities("headon", -3, 0, 5, 0);
        checkOutput("headon count", 32'(bus.collisionCount), 32'd1);

        $display("[TB] separating pair");
        doReset();
        applyStimulus(100, 100, -5, 0, 120, 100, 3, 0);
        runFrame("separating", 1'b0, 1'b0);
        checkVelocities("separating", 0, 0, 0, 0);
        checkOutput("separating count", 32'(bus.collisionCount), 32'd0);

        $display("[TB] distance boundary");
        doReset();
        applyStimulus(100, 100, 5, 0, 132, 100, -3, 0);
        runFrame("dist32", 1'b0, 1'b0);
        checkVelocities("dist32", 0, 0, 0, 0);
        checkOutput("dist32 count", 32'(bus.collisionCount), 32'd0);
        applyStimulus(100, 100, 5, 0, 131, 100, -3, 0);
        runFrame("dist31", 1'b1, 1'b0);
        checkVelocities("dist31", -3, 0, 5, 0);
        checkOutput("dist31 count", 32'(bus.collisionCount), 32'd1);

        $display("[TB] dominant Y");
        doReset();
        applyStimulus(100, 100, 2, 4, 110, 125, 1, -6);
        runFrame("domY", 1'b1, 1'b0);
        checkVelocities("domY", 2, -6, 1, 4);
        checkOutput("domY count", 32'(bus.collisionCount), 32'd1);

        $display("[TB] cooldown over six frames");
        doReset();
        applyStimulus(100, 100, 5, 0, 120, 100, -3, 0);
        for (int f = 1; f <= 6; f++) begin
            runFrame($sformatf("cool%0d", f), (f == 1) || (f == 6), f == 1);
            checkOutput($sformatf("cool%0d count", f), 32'(bus.collisionCount), (f == 6) ? 32'd2 : 32'd1);
        end
        checkVelocities("cool", -3, 0, 5, 0);

        $display("[TB] reset clears outputs");
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkIdleZero("clear");

        $display("[TB] reset during DETECT");
        applyStimulus(100, 100, 5, 0, 120, 100, -3, 0);
        bus.startOfFrame = 1'b1;
        nextCycle();
        bus.startOfFrame = 1'b0;
        nextCycle();
        checkOutput("abort busy@detect", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkIdleZero("abort");
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            if (bus.velocityWriteEnableA || bus.velocityWriteEnableB || bus.collisionPulse) seen++;
        end
        checkOutput("abort strobes", 32'(seen), 32'd0);
        checkOutput("abort count", 32'(bus.collisionCount), 32'd0);

        $display("[TB] enable low");
        bus.enable       = 1'b0;
        bus.startOfFrame = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            bus.startOfFrame = 1'b0;
            if (bus.busy) seen++;
        end
        checkOutput("disabled busy cycles", 32'(seen), 32'd0);
        checkOutput("disabled count", 32'(bus.collisionCount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
